// File: rtl/serial_frame_rx_pkg.sv
// Shared constants for the serial frame receiver.
// Latency: none, constants only. Backpressure: not applicable.
package serial_frame_rx_pkg;
  localparam int SYNC_STAGES = 2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_LATCH = 2'd2;
endpackage

// File: rtl/serial_frame_rx_sync_edge.sv
// Brings one asynchronous line into clk and flags its rising edge.
// Latency: level and rise are valid SYNC_STAGES cycles after the input changes. Backpressure: none.
module serial_frame_rx_sync_edge
  import serial_frame_rx_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic lvl,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  // Rise is decoded from flops only, so it is glitch-free in the clk domain.
  assign lvl  = sync_q[SYNC_STAGES-1];
  assign rise = lvl & ~prev_q;

endmodule

// File: rtl/serial_frame_rx.sv
// Deserialises clock/data/latch/clear serial frames into a WIDTH-bit word.
// Latency: word visible ~4 clk after the external latch edge. Backpressure: none; unread words are overwritten and flagged by overrun.
module serial_frame_rx
  import serial_frame_rx_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_clk,
  input  logic             s_data,
  input  logic             s_pen,
  input  logic             s_clrn,
  input  logic             rd_ack,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             overrun,
  output logic             frame_err,
  output logic [CNT_W-1:0] bit_cnt,
  output logic [7:0]       frame_cnt
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WIDTH + 1);

  logic clk_rise, data_lvl, pen_rise, clrn_lvl;
  logic clk_lvl_unused, data_rise_unused, pen_lvl_unused, clrn_rise_unused;

  serial_frame_rx_sync_edge u_sync_clk  (.clk(clk), .rst(rst), .din(s_clk),  .lvl(clk_lvl_unused), .rise(clk_rise));
  serial_frame_rx_sync_edge u_sync_data (.clk(clk), .rst(rst), .din(s_data), .lvl(data_lvl),       .rise(data_rise_unused));
  serial_frame_rx_sync_edge u_sync_pen  (.clk(clk), .rst(rst), .din(s_pen),  .lvl(pen_lvl_unused), .rise(pen_rise));
  serial_frame_rx_sync_edge u_sync_clrn (.clk(clk), .rst(rst), .din(s_clrn), .lvl(clrn_lvl),       .rise(clrn_rise_unused));

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d, cnt_next;
  logic             data_valid_q, data_valid_d;
  logic             overrun_q, overrun_d;
  logic             frame_err_q, frame_err_d;
  logic [7:0]       frame_cnt_q, frame_cnt_d;

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    data_out_d   = data_out_q;
    bit_cnt_d    = bit_cnt_q;
    data_valid_d = data_valid_q;
    overrun_d    = overrun_q;
    frame_err_d  = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    cnt_next     = (bit_cnt_q == CNT_SAT) ? bit_cnt_q : bit_cnt_q + CNT_W'(1);

    if (rd_ack && data_valid_q) begin
      data_valid_d = 1'b0;
      overrun_d    = 1'b0;
    end

    case (state_q)
      ST_IDLE, ST_SHIFT: begin
        if (clk_rise) begin
          shreg_d   = {shreg_q[WIDTH-2:0], data_lvl};
          bit_cnt_d = cnt_next;
          state_d   = ST_SHIFT;
        end
        // A coincident shift is already folded into bit_cnt_d here.
        if (pen_rise) begin
          if (bit_cnt_d == '0) begin
            frame_err_d = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            state_d = ST_LATCH;
          end
        end
      end
      ST_LATCH: begin
        if (bit_cnt_q == CNT_FULL) begin
          data_out_d   = shreg_q;
          data_valid_d = 1'b1;
          frame_cnt_d  = frame_cnt_q + 8'd1;
          if (data_valid_q && !rd_ack) overrun_d = 1'b1;
        end else begin
          frame_err_d = 1'b1;
        end
        bit_cnt_d = '0;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Clear overrides shift and latch but leaves the frame count and overrun alone.
    if (!clrn_lvl) begin
      shreg_d      = '0;
      bit_cnt_d    = '0;
      data_out_d   = '0;
      data_valid_d = 1'b0;
      state_d      = ST_IDLE;
      frame_err_d  = 1'b0;
      frame_cnt_d  = frame_cnt_q;
      overrun_d    = (rd_ack && data_valid_q) ? 1'b0 : overrun_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      shreg_q      <= '0;
      data_out_q   <= '0;
      bit_cnt_q    <= '0;
      data_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      frame_cnt_q  <= 8'd0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      data_out_q   <= data_out_d;
      bit_cnt_q    <= bit_cnt_d;
      data_valid_q <= data_valid_d;
      overrun_q    <= overrun_d;
      frame_err_q  <= frame_err_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign overrun    = overrun_q;
  assign frame_err  = frame_err_q;
  assign bit_cnt    = bit_cnt_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: a 64-bit instance for directed frames and a 16-bit one for random frames and count wrap.
module tb_serial_frame_rx;

  logic clk = 1'b0;
  logic rst, s_clk, s_data, s_pen, s_clrn, rd_ack;
  always #5 clk = ~clk;

  logic [63:0] d64;  logic v64, o64, e64;  logic [6:0] bc64;  logic [7:0] fc64;
  logic [15:0] d16;  logic v16, o16, e16;  logic [4:0] bc16;  logic [7:0] fc16;

  serial_frame_rx #(.WIDTH(64), .CNT_W(7)) u_dut64 (
    .clk(clk), .rst(rst), .s_clk(s_clk), .s_data(s_data), .s_pen(s_pen), .s_clrn(s_clrn),
    .rd_ack(rd_ack), .data_out(d64), .data_valid(v64), .overrun(o64), .frame_err(e64),
    .bit_cnt(bc64), .frame_cnt(fc64));

  serial_frame_rx #(.WIDTH(16), .CNT_W(5)) u_dut16 (
    .clk(clk), .rst(rst), .s_clk(s_clk), .s_data(s_data), .s_pen(s_pen), .s_clrn(s_clrn),
    .rd_ack(rd_ack), .data_out(d16), .data_valid(v16), .overrun(o16), .frame_err(e16),
    .bit_cnt(bc16), .frame_cnt(fc16));

  int total = 0;
  int bad   = 0;
  int err64 = 0;
  int err16 = 0;

  always @(negedge clk) begin
    if (e64) err64++;
    if (e16) err16++;
  end

  typedef struct {
    int           n;
    logic [127:0] pat;
    bit           ack;
    logic [63:0]  d;
    bit           v;
    bit           o;
    int           fc;
    int           errs;
    int           bc;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ack_pulse();
    rd_ack = 1'b1;
    cyc(1);
    rd_ack = 1'b0;
    cyc(1);
  endtask

  // MSB first; with merge the last bit's clock rise is left for pen_pulse.
  task automatic send_bits(input int n, input logic [127:0] pat, input bit merge);
    for (int i = n - 1; i >= 0; i--) begin
      s_data = pat[7'(i)];
      cyc(5);
      if (!(merge && i == 0)) begin
        s_clk = 1'b1;
        cyc(5);
        s_clk = 1'b0;
      end
    end
  endtask

  task automatic pen_pulse(input bit with_clk, input bit sel, input int ack_at, output int lat);
    logic [7:0] f0;
    lat = 0;
    f0 = sel ? fc16 : fc64;
    s_pen = 1'b1;
    if (with_clk) s_clk = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      rd_ack = (i == ack_at);
      @(posedge clk);
      #1;
      if (lat == 0 && (sel ? fc16 : fc64) != f0) lat = i;
      @(negedge clk);
      if (i == 6) begin
        s_pen = 1'b0;
        s_clk = 1'b0;
      end
    end
    rd_ack = 1'b0;
  endtask

  task automatic chk64(input string nm, input logic [63:0] d, input bit v, input bit o, input int fc);
    chk({nm, "_data"}, d64, d);
    chk({nm, "_valid"}, 64'(v64), 64'(v));
    chk({nm, "_overrun"}, 64'(o64), 64'(o));
    chk({nm, "_fcnt"}, 64'(fc64), 64'(fc));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, lat0, e0, base16, good, len, mfc, merr;
    logic [127:0] pat;
    logic [15:0] mdata;
    bit mv, mo, merge;

    rst = 1'b1; s_clk = 1'b0; s_data = 1'b0; s_pen = 1'b0; s_clrn = 1'b1; rd_ack = 1'b0;
    lat0 = 0;

    vecs[0] = '{64, 128'hDEADBEEF01234567, 1'b0, 64'hDEADBEEF01234567, 1'b1, 1'b0, 1, 0, 64};
    vecs[1] = '{63, 128'h5555555555555555, 1'b0, 64'hDEADBEEF01234567, 1'b1, 1'b0, 1, 1, 63};
    vecs[2] = '{70, 128'h3F0F0F0F0F0F0F0F0F, 1'b0, 64'hDEADBEEF01234567, 1'b1, 1'b0, 1, 2, 65};
    vecs[3] = '{64, 128'h1, 1'b1, 64'h1, 1'b1, 1'b0, 2, 2, 64};
    vecs[4] = '{64, 128'h2, 1'b0, 64'h2, 1'b1, 1'b1, 3, 2, 64};

    cyc(3);
    chk64("reset", 64'h0, 1'b0, 1'b0, 0);
    chk("reset_bitcnt", 64'(bc64), 64'd0);
    chk("reset_ferr", 64'(e64), 64'd0);
    rst = 1'b0;
    cyc(5);

    for (int k = 0; k < 5; k++) begin
      if (vecs[k].ack) ack_pulse();
      send_bits(vecs[k].n, vecs[k].pat, 1'b0);
      chk($sformatf("vec%0d_bitcnt_pre", k), 64'(bc64), 64'(vecs[k].bc));
      pen_pulse(1'b0, 1'b0, 0, lat);
      if (k == 0) begin
        lat0 = lat;
        chk("latch_latency_3to4", 64'((lat >= 3 && lat <= 4) ? 1 : 0), 64'd1);
      end
      chk64($sformatf("vec%0d", k), vecs[k].d, vecs[k].v, vecs[k].o, vecs[k].fc);
      chk($sformatf("vec%0d_errs", k), 64'(err64), 64'(vecs[k].errs));
      chk($sformatf("vec%0d_bitcnt_post", k), 64'(bc64), 64'd0);
    end

    ack_pulse();
    chk64("ack_clears", 64'h2, 1'b0, 1'b0, 3);
    ack_pulse();
    chk64("ack_idle_ignored", 64'h2, 1'b0, 1'b0, 3);

    send_bits(64, 128'h3, 1'b0);
    pen_pulse(1'b0, 1'b0, 0, lat);
    send_bits(64, 128'h4, 1'b0);
    pen_pulse(1'b0, 1'b0, lat0, lat);
    chk64("ack_with_latch", 64'h4, 1'b1, 1'b0, 5);

    ack_pulse();
    send_bits(64, 128'h0123456789ABCDEF, 1'b1);
    pen_pulse(1'b1, 1'b0, 0, lat);
    chk64("clk_pen_same_cycle", 64'h0123456789ABCDEF, 1'b1, 1'b0, 6);
    chk("clk_pen_same_errs", 64'(err64), 64'd2);

    send_bits(64, 128'h5, 1'b0);
    pen_pulse(1'b0, 1'b0, 0, lat);
    chk64("pre_clear", 64'h5, 1'b1, 1'b1, 7);
    send_bits(20, 128'hFFFFF, 1'b0);
    chk("pre_clear_bitcnt", 64'(bc64), 64'd20);
    s_clrn = 1'b0;
    cyc(5);
    s_clrn = 1'b1;
    cyc(5);
    chk64("after_clear", 64'h0, 1'b0, 1'b1, 7);
    chk("after_clear_bitcnt", 64'(bc64), 64'd0);
    send_bits(64, 128'hCAFEF00D12345678, 1'b0);
    pen_pulse(1'b0, 1'b0, 0, lat);
    chk64("frame_after_clear", 64'hCAFEF00D12345678, 1'b1, 1'b1, 8);
    chk("frame_after_clear_errs", 64'(err64), 64'd2);

    send_bits(30, 128'h2AAAAAAA, 1'b0);
    e0 = err64;
    rst = 1'b1;
    cyc(2);
    chk64("mid_frame_reset", 64'h0, 1'b0, 1'b0, 0);
    chk("mid_frame_reset_bitcnt", 64'(bc64), 64'd0);
    rst = 1'b0;
    cyc(10);
    chk("mid_frame_reset_no_ferr", 64'(err64), 64'(e0));

    // Random frames on the 16-bit instance against a frame-level model.
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(5);
    base16 = err16;
    mdata = 16'h0; mv = 1'b0; mo = 1'b0; mfc = 0; merr = 0; good = 0;
    for (int it = 0; it < 400 && good < 258; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        ack_pulse();
        if (mv) begin
          mv = 1'b0;
          mo = 1'b0;
        end
      end
      len = ($urandom_range(0, 9) < 8) ? 16 : int'($urandom_range(0, 20));
      pat = {$urandom, $urandom, $urandom, $urandom};
      merge = (len > 0) && ($urandom_range(0, 1) == 1);
      send_bits(len, pat, merge);
      if (!merge) chk("rnd_bitcnt_pre", 64'(bc16), 64'((len > 17) ? 17 : len));
      pen_pulse(merge, 1'b1, 0, lat);
      if (len == 16) begin
        if (mv) mo = 1'b1;
        mdata = pat[15:0];
        mv = 1'b1;
        mfc = (mfc + 1) % 256;
        good++;
      end else begin
        merr++;
      end
      chk("rnd_data", 64'(d16), 64'(mdata));
      chk("rnd_valid", 64'(v16), 64'(mv));
      chk("rnd_overrun", 64'(o16), 64'(mo));
      chk("rnd_fcnt", 64'(fc16), 64'(mfc));
      chk("rnd_errs", 64'(err16 - base16), 64'(merr));
      chk("rnd_bitcnt_post", 64'(bc16), 64'd0);
    end
    chk("rnd_reached_wrap", 64'((good >= 256) ? 1 : 0), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
